lstm_sequence_controller: RTL and testbench

Sequencer that drives the prefetcher `network` through one full LSTM sequence per inference: clears recurrent state, issues MAX_SAMPLES input symbols with `newSample` pulses, and waits for `dataReady` after each step. It enables the dense layer on the final timestep and captures the dense output into a valid/ready result port. It replaces the per-sequence reset pulsing and dense_enable toggling currently done by hand around the `network` instance, and adds a watchdog for hung steps.

---
 rtl/lstm_sequence_controller_pkg.sv | 32 +++
 rtl/lstm_sequence_controller_watchdog.sv | 32 +++
 rtl/lstm_sequence_controller.sv | 153 +++++++++++++++
 tb/tb_lstm_sequence_controller.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_sequence_controller_pkg.sv
// Shared definitions for the LSTM sequence controller: state encoding,
// fixed-point word width and a constant-friendly clog2.
package lstm_sequence_controller_pkg;

  localparam int QN = 8;
  localparam int QM = 9;
  localparam int BITWIDTH_DEF = QN + QM + 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CLEAR      = 3'd1;
  localparam logic [2:0] ST_FETCH      = 3'd2;
  localparam logic [2:0] ST_ISSUE      = 3'd3;
  localparam logic [2:0] ST_WAIT_STEP  = 3'd4;
  localparam logic [2:0] ST_DENSE_WAIT = 3'd5;
  localparam logic [2:0] ST_OUTPUT     = 3'd6;
  localparam logic [2:0] ST_ERROR      = 3'd7;

  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lstm_sequence_controller_watchdog.sv
// Down-counting watchdog: reloads on clear, counts while enabled and flags
// expiry once LIMIT cycles have been spent without a clear.
module seq_watchdog
  import lstm_sequence_controller_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (clog2_f(LIMIT) < 1) ? 1 : clog2_f(LIMIT);
  localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/lstm_sequence_controller.sv
// Drives the LSTM `network` through one full sequence per inference:
// clear, per-step symbol issue, dense enable on the last step, result capture.
module lstm_sequence_controller
  import lstm_sequence_controller_pkg::*;
#(
  parameter int RAW_INPUT_BIT  = 1,
  parameter int BITWIDTH       = BITWIDTH_DEF,
  parameter int FINAL_OUT_SIZE = 16,
  parameter int MAX_SAMPLES    = 48,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int STEP_W        = clog2_f(MAX_SAMPLES),
  localparam int RES_W         = FINAL_OUT_SIZE * BITWIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     sym_valid,
  input  logic [RAW_INPUT_BIT-1:0] sym_data,
  output logic                     sym_ready,
  output logic [RAW_INPUT_BIT-1:0] net_input,
  output logic                     net_new_sample,
  output logic                     net_clear,
  input  logic                     net_data_ready,
  output logic                     net_dense_enable,
  input  logic                     net_result_ready,
  input  logic [RES_W-1:0]         net_result,
  output logic                     result_valid,
  output logic [RES_W-1:0]         result_data,
  input  logic                     result_ready,
  output logic                     busy,
  output logic [STEP_W-1:0]        step_idx,
  output logic                     timeout_err,
  output logic [2:0]               dbg_state
);

  localparam int CLR_W = clog2_f(CLEAR_CYCLES + 1);
  localparam logic [CLR_W-1:0]  CLR_LAST    = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(MAX_SAMPLES - 1);
  localparam logic [STEP_W-1:0] PENULT_STEP = STEP_W'(MAX_SAMPLES - 2);

  state_t           state;
  state_t           state_next;
  logic             rdy_q;
  logic             start_q;
  logic             rdy_edge;
  logic             watched;
  logic             wd_clear;
  logic             wd_expire;
  logic [CLR_W-1:0] clr_cnt;

  // Only a fresh rising edge of dataReady completes a step; a level left
  // high by the previous step is ignored.
  assign rdy_edge = net_data_ready && !rdy_q;
  assign watched  = (state == ST_FETCH) || (state == ST_WAIT_STEP) ||
                    (state == ST_DENSE_WAIT);
  assign wd_clear = (state_next != state);

  seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (watched),
    .expire (wd_expire)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (start) state_next = ST_CLEAR;
      ST_CLEAR:      if (clr_cnt == CLR_LAST) state_next = ST_FETCH;
      ST_FETCH: begin
        if (sym_valid)      state_next = ST_ISSUE;
        else if (wd_expire) state_next = ST_ERROR;
      end
      ST_ISSUE:      state_next = ST_WAIT_STEP;
      ST_WAIT_STEP: begin
        if (rdy_edge)       state_next = (step_idx == LAST_STEP) ? ST_DENSE_WAIT : ST_FETCH;
        else if (wd_expire) state_next = ST_ERROR;
      end
      ST_DENSE_WAIT: begin
        if (net_result_ready) state_next = ST_OUTPUT;
        else if (wd_expire)   state_next = ST_ERROR;
      end
      ST_OUTPUT:     if (result_ready) state_next = start ? ST_CLEAR : ST_IDLE;
      ST_ERROR:      if (start && !start_q) state_next = ST_CLEAR;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      rdy_q            <= 1'b0;
      start_q          <= 1'b0;
      clr_cnt          <= '0;
      step_idx         <= '0;
      timeout_err      <= 1'b0;
      net_input        <= '0;
      net_dense_enable <= 1'b0;
      result_valid     <= 1'b0;
      result_data      <= '0;
    end else begin
      state   <= state_next;
      rdy_q   <= net_data_ready;
      start_q <= start;
      clr_cnt <= ((state == ST_CLEAR) && (state_next == ST_CLEAR)) ? clr_cnt + 1'b1 : '0;

      if ((state_next == ST_CLEAR) && (state != ST_CLEAR)) begin
        step_idx    <= '0;
        timeout_err <= 1'b0;
      end

      if ((state == ST_FETCH) && sym_valid) begin
        net_input <= sym_data;
      end

      // Dense layer must see the whole final step, so it is armed on the
      // completion of the second-to-last step.
      if ((state == ST_WAIT_STEP) && rdy_edge) begin
        if (step_idx != LAST_STEP) step_idx <= step_idx + 1'b1;
        if (step_idx == PENULT_STEP) net_dense_enable <= 1'b1;
      end

      if ((state == ST_DENSE_WAIT) && (state_next != ST_DENSE_WAIT)) begin
        net_dense_enable <= 1'b0;
      end

      if ((state_next == ST_ERROR) && (state != ST_ERROR)) begin
        timeout_err      <= 1'b1;
        net_dense_enable <= 1'b0;
      end

      // Result port: valid/ready handshake; result_data is loaded only when
      // no result is pending and transfers on result_valid && result_ready.
      if ((state == ST_DENSE_WAIT) && net_result_ready) begin
        result_data  <= net_result;
        result_valid <= 1'b1;
      end else if ((state == ST_OUTPUT) && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

  assign sym_ready      = (state == ST_FETCH);
  assign net_new_sample = (state == ST_ISSUE);
  assign net_clear      = (state == ST_CLEAR) || (state == ST_ERROR);
  assign busy           = (state != ST_IDLE) && (state != ST_ERROR);
  assign dbg_state      = state;

endmodule

// File: tb/tb_lstm_sequence_controller.sv
// Directed bench for lstm_sequence_controller with a small behavioural
// model of the network's dataReady / result handshake.
module tb_lstm_sequence_controller;
  import lstm_sequence_controller_pkg::*;

  localparam int RAW   = 1;
  localparam int BW    = 18;
  localparam int FOS   = 16;
  localparam int MAXS  = 4;
  localparam int CLRC  = 2;
  localparam int TOC   = 16;
  localparam int RES_W = FOS * BW;
  localparam int SW    = 2;
  localparam logic [RES_W-1:0] PAT_A = {36{8'hA5}};
  localparam logic [RES_W-1:0] PAT_B = {36{8'h3C}};

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic             sym_valid = 1'b0;
  logic [RAW-1:0]   sym_data = '0;
  logic             sym_ready;
  logic [RAW-1:0]   net_input;
  logic             net_new_sample;
  logic             net_clear;
  logic             net_data_ready = 1'b0;
  logic             net_dense_enable;
  logic             net_result_ready = 1'b0;
  logic [RES_W-1:0] net_result = PAT_A;
  logic             result_valid;
  logic [RES_W-1:0] result_data;
  logic             result_ready = 1'b0;
  logic             busy;
  logic [SW-1:0]    step_idx;
  logic             timeout_err;
  logic [2:0]       dbg_state;

  int vectors = 0;
  int errors  = 0;

  logic [RAW-1:0] exp_q[$];
  logic [RAW-1:0] obs_q[$];
  int  ns_count   = 0;
  int  de_rise_ns = -1;
  int  fetch_run  = 0;
  int  fetch_max  = 0;
  int  rdy_cnt    = 0;
  bit  de_prev    = 1'b0;
  bit  stuck_hi   = 1'b0;

  lstm_sequence_controller #(
    .RAW_INPUT_BIT (RAW),
    .BITWIDTH      (BW),
    .FINAL_OUT_SIZE(FOS),
    .MAX_SAMPLES   (MAXS),
    .CLEAR_CYCLES  (CLRC),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .sym_valid       (sym_valid),
    .sym_data        (sym_data),
    .sym_ready       (sym_ready),
    .net_input       (net_input),
    .net_new_sample  (net_new_sample),
    .net_clear       (net_clear),
    .net_data_ready  (net_data_ready),
    .net_dense_enable(net_dense_enable),
    .net_result_ready(net_result_ready),
    .net_result      (net_result),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .result_ready    (result_ready),
    .busy            (busy),
    .step_idx        (step_idx),
    .timeout_err     (timeout_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "global timeout");
  end

  // Network model and observation, 1 time unit after each rising edge.
  // dataReady rises 5 cycles after a newSample and drops on the next one
  // (unless stuck_hi); data_result_Ready follows dense_enable && dataReady.
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      net_data_ready   = 1'b0;
      net_result_ready = 1'b0;
      rdy_cnt          = 0;
    end else begin
      if (net_new_sample) begin
        ns_count++;
        obs_q.push_back(net_input);
        if (!(stuck_hi && net_data_ready)) net_data_ready = 1'b0;
        rdy_cnt = 5;
      end else if (rdy_cnt != 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) net_data_ready = 1'b1;
      end
      net_result_ready = net_dense_enable && net_data_ready;
      if (net_dense_enable && !de_prev) de_rise_ns = ns_count;
      de_prev = net_dense_enable;
      if (dbg_state == ST_FETCH) begin
        fetch_run++;
        if (fetch_run > fetch_max) fetch_max = fetch_run;
      end else begin
        fetch_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_scoreboard();
    exp_q.delete();
    obs_q.delete();
    ns_count   = 0;
    de_rise_ns = -1;
    fetch_run  = 0;
    fetch_max  = 0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    sym_valid    = 1'b0;
    result_ready = 1'b0;
    stuck_hi     = 1'b0;
    net_result   = PAT_A;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_scoreboard();
    @(negedge clock);
  endtask

  task automatic start_seq(input bit hold);
    start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
  endtask

  // gap < 0: symbol presented before FETCH; gap >= 0: wait for sym_ready,
  // then idle gap cycles before presenting the symbol.
  task automatic feed(input int n, input int gap, input logic [7:0] syms, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      exp_q.push_back(syms[i]);
      if (gap < 0) begin
        sym_valid = 1'b1;
        sym_data  = syms[i];
      end
      while (!sym_ready && t < 200) begin
        @(negedge clock);
        t++;
      end
      if (!sym_ready) begin
        ok = 1'b0;
        sym_valid = 1'b0;
        return;
      end
      if (gap > 0) repeat (gap) @(negedge clock);
      sym_valid = 1'b1;
      sym_data  = syms[i];
      @(negedge clock);
      sym_valid = 1'b0;
    end
  endtask

  task automatic wait_result(output int t);
    t = 0;
    while (!result_valid && t < 400) begin
      @(negedge clock);
      t++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    vectors++;
    if ({sym_ready, net_new_sample, net_clear, net_dense_enable, result_valid, busy, timeout_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {sym_ready, net_new_sample, net_clear, net_dense_enable, result_valid, busy, timeout_err});
    end
    vectors++;
    if ({step_idx, net_input} !== '0 || result_data !== '0) begin
      errors++; $display("FAIL reset_data: step_idx %0d net_input %0b result_data %h expected all 0",
        step_idx, net_input, result_data);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_hold: state %0d busy %b expected %0d 0", dbg_state, busy, ST_IDLE);
    end
  endtask

  task automatic test_full_sequence();
    bit ok;
    int t;
    do_reset();
    start_seq(1'b0);
    feed(4, -1, 8'b0000_1101, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL t1_feed: got timeout expected 4 symbols accepted"); end
    wait_result(t);
    vectors++;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL t1_result_valid: got %b expected 1", result_valid); end
    vectors++;
    if (result_data !== PAT_A) begin errors++; $display("FAIL t1_result_data: got %h expected %h", result_data, PAT_A); end
    vectors++;
    if (ns_count !== 4) begin errors++; $display("FAIL t1_new_sample_count: got %0d expected 4", ns_count); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t1_net_input[%0d]: got %b expected %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    vectors++;
    if (de_rise_ns !== 3) begin errors++; $display("FAIL t1_dense_rise: got after %0d samples expected 3", de_rise_ns); end
    vectors++;
    if (fetch_max !== 1) begin errors++; $display("FAIL t1_fetch_same_cycle: got %0d fetch cycles expected 1", fetch_max); end
    vectors++;
    if (net_dense_enable !== 1'b0 || step_idx !== 2'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL t1_output_state: dense %b step %0d busy %b expected 0 3 1", net_dense_enable, step_idx, busy);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL t1_accept: valid %b state %0d busy %b expected 0 %0d 0", result_valid, dbg_state, busy, ST_IDLE);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    stuck_hi = 1'b1;
    start_seq(1'b1);
    feed(2, -1, 8'b0000_0010, ok);
    vectors++;
    if (!ok || net_new_sample !== 1'b1) begin
      errors++; $display("FAIL t2_issue_step1: feed_ok %b new_sample %b expected 1 1", ok, net_new_sample);
    end
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n !== TOC + 1) begin errors++; $display("FAIL t2_timeout_latency: got %0d cycles expected %0d", n, TOC + 1); end
    vectors++;
    if (timeout_err !== 1'b1 || net_clear !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_ERROR) begin
      errors++; $display("FAIL t2_error_outputs: err %b clear %b busy %b state %0d expected 1 1 0 %0d",
        timeout_err, net_clear, busy, dbg_state, ST_ERROR);
    end
    vectors++;
    if (step_idx !== 2'd1 || ns_count !== 2 || net_dense_enable !== 1'b0) begin
      errors++; $display("FAIL t2_no_advance: step %0d samples %0d dense %b expected 1 2 0", step_idx, ns_count, net_dense_enable);
    end
  endtask

  task automatic test_error_restart();
    repeat (5) @(negedge clock);
    vectors++;
    if (dbg_state !== ST_ERROR || timeout_err !== 1'b1) begin
      errors++; $display("FAIL t6_hold_start: state %0d err %b expected %0d 1", dbg_state, timeout_err, ST_ERROR);
    end
    start = 1'b0;
    @(negedge clock);
    vectors++;
    if (dbg_state !== ST_ERROR) begin errors++; $display("FAIL t6_start_low: state %0d expected %0d", dbg_state, ST_ERROR); end
    start = 1'b1;
    @(negedge clock);
    vectors++;
    if (dbg_state !== ST_CLEAR || timeout_err !== 1'b0 || net_clear !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL t6_restart: state %0d err %b clear %b busy %b expected %0d 0 1 1",
        dbg_state, timeout_err, net_clear, busy, ST_CLEAR);
    end
    start = 1'b0;
    stuck_hi = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t;
    do_reset();
    start_seq(1'b1);
    feed(4, -1, 8'b0000_0011, ok);
    wait_result(t);
    vectors++;
    if (!ok || result_valid !== 1'b1 || result_data !== PAT_A) begin
      errors++; $display("FAIL t3_result: feed_ok %b valid %b data %h expected 1 1 %h", ok, result_valid, result_data, PAT_A);
    end
    net_result = PAT_B;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      vectors++;
      if (result_valid !== 1'b1 || result_data !== PAT_A) begin
        errors++; $display("FAIL t3_hold[%0d]: valid %b data %h expected 1 %h", i, result_valid, result_data, PAT_A);
      end
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    vectors++;
    if (dbg_state !== ST_CLEAR || step_idx !== 2'd0 || result_valid !== 1'b0 || net_clear !== 1'b1) begin
      errors++; $display("FAIL t3_restart: state %0d step %0d valid %b clear %b expected %0d 0 0 1",
        dbg_state, step_idx, result_valid, net_clear, ST_CLEAR);
    end
    @(negedge clock);
    vectors++;
    if (net_clear !== 1'b1) begin errors++; $display("FAIL t3_clear_cycle2: got %b expected 1", net_clear); end
    @(negedge clock);
    vectors++;
    if (net_clear !== 1'b0 || dbg_state !== ST_FETCH) begin
      errors++; $display("FAIL t3_clear_end: clear %b state %0d expected 0 %0d", net_clear, dbg_state, ST_FETCH);
    end
    start = 1'b0;
  endtask

  task automatic test_gapped_symbols();
    bit ok;
    int t;
    do_reset();
    start_seq(1'b0);
    feed(4, 3, 8'b0000_0110, ok);
    wait_result(t);
    vectors++;
    if (!ok || result_valid !== 1'b1 || result_data !== PAT_A) begin
      errors++; $display("FAIL t4_result: feed_ok %b valid %b data %h expected 1 1 %h", ok, result_valid, result_data, PAT_A);
    end
    vectors++;
    if (fetch_max !== 4) begin errors++; $display("FAIL t4_fetch_wait: got %0d cycles expected 4", fetch_max); end
    vectors++;
    if (timeout_err !== 1'b0 || ns_count !== 4) begin
      errors++; $display("FAIL t4_no_timeout: err %b samples %0d expected 0 4", timeout_err, ns_count);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t4_net_input[%0d]: got %b expected %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    bit ok;
    int t;
    do_reset();
    start_seq(1'b0);
    feed(3, -1, 8'b0000_0101, ok);
    @(negedge clock);
    vectors++;
    if (!ok || dbg_state !== ST_WAIT_STEP || step_idx !== 2'd2) begin
      errors++; $display("FAIL t5_pre_reset: feed_ok %b state %0d step %0d expected 1 %0d 2", ok, dbg_state, step_idx, ST_WAIT_STEP);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (dbg_state !== ST_IDLE ||
        {sym_ready, net_new_sample, net_clear, net_dense_enable, result_valid, busy, timeout_err} !== 7'b0 ||
        step_idx !== '0 || net_input !== '0) begin
      errors++; $display("FAIL t5_async_reset: state %0d ctrl %b step %0d input %b expected %0d 0000000 0 0", dbg_state,
        {sym_ready, net_new_sample, net_clear, net_dense_enable, result_valid, busy, timeout_err}, step_idx, net_input, ST_IDLE);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL t5_reset_edge: state %0d busy %b expected %0d 0", dbg_state, busy, ST_IDLE);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    clear_scoreboard();
    start_seq(1'b0);
    feed(4, -1, 8'b0000_1001, ok);
    wait_result(t);
    vectors++;
    if (!ok || result_valid !== 1'b1 || result_data !== PAT_A || ns_count !== 4 || step_idx !== 2'd3) begin
      errors++; $display("FAIL t5_clean_run: feed_ok %b valid %b data %h samples %0d step %0d expected 1 1 %h 4 3",
        ok, result_valid, result_data, ns_count, step_idx, PAT_A);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t5_net_input[%0d]: got %b expected %b", i, (i < obs_q.size()) ? obs_q[i] : 1'bx, exp_q[i]);
      end
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL t5_accept: valid %b state %0d expected 0 %0d", result_valid, dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_sequence();
    test_timeout();
    test_error_restart();
    test_back_to_back();
    test_gapped_symbols();
    test_reset_mid_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
